// File: rtl/dark_channel_min_filter.sv
// Streaming 3x3 minimum filter: windowed dark channel plus per-channel minima, two-cycle latency.
// Define DCP_FRAME_STATS_EN to build the per-frame dark_max tracker; otherwise dark_max is tied low.
module dark_channel_min_filter #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 48
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       sof,
   input  logic [7:0] r_in,
   input  logic [7:0] g_in,
   input  logic [7:0] b_in,
   output logic       out_valid,
   output logic [7:0] I_dark,
   output logic [7:0] min_all,
   output logic [7:0] rmin,
   output logic [7:0] gmin,
   output logic [7:0] bmin,
   output logic       out_eof,
   output logic [7:0] dark_max
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H + 2);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);
   localparam logic [YW-1:0] Y_PAD_END = YW'(IMG_H + 1);
   localparam logic [23:0]   PAD       = 24'hFF_FFFF;

   logic [1:0]    state;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [XW-1:0] bx;
   logic [YW-1:0] by;
   logic          accept;
   logic          restart;
   logic          proc;
   logic          emit;
   logic          last_pad;
   logic [23:0]   pix;
   logic [23:0]   row_m1;
   logic [23:0]   row_m2;
   logic [23:0]   top;
   logic [23:0]   mid;

   logic [23:0]   lb0 [IMG_W];
   logic [23:0]   lb1 [IMG_W];
   logic          lb_sel;

   logic [2:0][2:0][23:0] win;
   logic [XW-1:0] x1;
   logic          v1;
   logic          e1;

   logic [7:0]    rm;
   logic [7:0]    gm;
   logic [7:0]    bm;
   logic [7:0]    dk;
   logic [7:0]    cm;
   logic [23:0]   p;

   assign in_ready = rst_n && (state != S_DRAIN);
   assign accept   = in_valid && in_ready;
   assign restart  = accept && sof;
   // Every accepted beat outside IDLE is processed; in IDLE only a sof beat is.
   assign proc     = restart || (accept && (state != S_IDLE)) || (state == S_DRAIN);
   assign emit     = proc && !restart && ((state == S_RUN) || (state == S_DRAIN));
   assign last_pad = (state == S_DRAIN) && (x == '0) && (y == Y_PAD_END);

   assign bx  = restart ? '0 : x;
   assign by  = restart ? '0 : y;
   assign pix = (state == S_DRAIN) ? PAD : {r_in, g_in, b_in};

   // lb_sel=0: lb0 holds row y-1 and lb1 row y-2; the current row overwrites the y-2 buffer.
   assign row_m1 = lb_sel ? lb1[bx] : lb0[bx];
   assign row_m2 = lb_sel ? lb0[bx] : lb1[bx];
   assign top    = (by >= YW'(2)) ? row_m2 : PAD;
   assign mid    = (by >= YW'(1)) ? row_m1 : PAD;

   always_ff @(posedge clk) begin
      if (proc) begin
         if (lb_sel) begin
            lb0[bx] <= pix;
         end else begin
            lb1[bx] <= pix;
         end
         win[0] <= win[1];
         win[1] <= win[2];
         win[2] <= {pix, mid, top};
         x1     <= bx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         x      <= '0;
         y      <= '0;
         lb_sel <= 1'b0;
         v1     <= 1'b0;
         e1     <= 1'b0;
      end else begin
         v1 <= emit;
         e1 <= emit && last_pad;
         if (proc) begin
            if (bx == X_LAST) begin
               x      <= '0;
               y      <= by + 1'b1;
               lb_sel <= ~lb_sel;
            end else begin
               x <= bx + 1'b1;
               y <= by;
            end
         end
         case (state)
            S_IDLE: begin
               if (restart) state <= S_FILL;
            end
            S_FILL: begin
               if (restart) begin
                  state <= S_FILL;
               end else if (accept && (x == '0) && (y == YW'(1))) begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (restart) begin
                  state <= S_FILL;
               end else if (accept && (x == X_LAST) && (y == Y_LAST)) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (last_pad) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Window columns are oldest..newest; at x1==0 the newest column belongs to the next
   // line and at x1==1 the oldest belongs to the previous one, so both are padded.
   always_comb begin
      rm = 8'hFF;
      gm = 8'hFF;
      bm = 8'hFF;
      p  = '0;
      for (int c = 0; c < 3; c++) begin
         for (int rr = 0; rr < 3; rr++) begin
            p = win[c][rr];
            if (((c == 0) && (x1 == XW'(1))) || ((c == 2) && (x1 == '0))) begin
               p = PAD;
            end
            if (p[23:16] < rm) rm = p[23:16];
            if (p[15:8]  < gm) gm = p[15:8];
            if (p[7:0]   < bm) bm = p[7:0];
         end
      end
      dk = (rm < gm) ? rm : gm;
      if (bm < dk) dk = bm;
      p  = win[1][1];
      cm = (p[23:16] < p[15:8]) ? p[23:16] : p[15:8];
      if (p[7:0] < cm) cm = p[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_eof   <= 1'b0;
         I_dark    <= 8'h00;
         min_all   <= 8'h00;
         rmin      <= 8'h00;
         gmin      <= 8'h00;
         bmin      <= 8'h00;
      end else begin
         out_valid <= v1;
         out_eof   <= v1 && e1;
         if (v1) begin
            I_dark  <= dk;
            min_all <= cm;
            rmin    <= rm;
            gmin    <= gm;
            bmin    <= bm;
         end
      end
   end

`ifdef DCP_FRAME_STATS_EN
   // A new sof wins over an in-flight output from the previous frame on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dark_max <= 8'h00;
      end else if (restart) begin
         dark_max <= 8'h00;
      end else if (v1 && (dk > dark_max)) begin
         dark_max <= dk;
      end
   end
`else
   assign dark_max = 8'h00;
`endif

endmodule

// File: tb/tb_dark_channel_min_filter.sv
// Randomized bench for dark_channel_min_filter against a direct 3x3 neighbourhood model.
module tb_dark_channel_min_filter;
   localparam int W = 8;
   localparam int H = 4;
   localparam int N = W * H;

   typedef struct {
      int         t;
      int         fid;
      logic       eof;
      logic [7:0] d;
      logic [7:0] m;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       sof = 1'b0;
   logic [7:0] r_in = 8'h00;
   logic [7:0] g_in = 8'h00;
   logic [7:0] b_in = 8'h00;
   logic       out_valid;
   logic [7:0] I_dark;
   logic [7:0] min_all;
   logic [7:0] rmin;
   logic [7:0] gmin;
   logic [7:0] bmin;
   logic       out_eof;
   logic [7:0] dark_max;

   dark_channel_min_filter #(.IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sof(sof),
      .r_in(r_in), .g_in(g_in), .b_in(b_in), .out_valid(out_valid), .I_dark(I_dark),
      .min_all(min_all), .rmin(rmin), .gmin(gmin), .bmin(bmin), .out_eof(out_eof),
      .dark_max(dark_max)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t        q[$];
   logic [23:0] img [H][W];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          fid = 0;
   int          n_fo = 0;
   logic        mon_en = 1'b0;
   logic        exp_v;
   exp_t        e;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
      n_cmp++;
      if (obs !== exp_val) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_val, cyc);
      end
   endtask

   function automatic logic [7:0] mn(input logic [7:0] a, input logic [7:0] b);
      return (a < b) ? a : b;
   endfunction

   // Output k is centred on raster pixel k; neighbours outside the frame are ignored.
   function automatic exp_t ref_out(input int k, input int t, input logic eof);
      exp_t        o;
      logic [23:0] px;
      int          cx, cy, xx, yy;
      cx = k % W;
      cy = k / W;
      o.t = t; o.fid = fid; o.eof = eof;
      o.d = 8'hFF; o.r = 8'hFF; o.g = 8'hFF; o.b = 8'hFF;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            yy = cy + dy;
            xx = cx + dx;
            if (yy >= 0 && yy < H && xx >= 0 && xx < W) begin
               px = img[yy][xx];
               o.r = mn(o.r, px[23:16]);
               o.g = mn(o.g, px[15:8]);
               o.b = mn(o.b, px[7:0]);
               o.d = mn(o.d, mn(px[23:16], mn(px[15:8], px[7:0])));
            end
         end
      end
      px = img[cy][cx];
      o.m = mn(px[23:16], mn(px[15:8], px[7:0]));
      return o;
   endfunction

   function automatic int exp_dark_max();
`ifdef DCP_FRAME_STATS_EN
      int   mx;
      exp_t o;
      mx = 0;
      for (int k = 0; k < N; k++) begin
         o = ref_out(k, 0, 1'b0);
         if (int'(o.d) > mx) mx = int'(o.d);
      end
      return mx;
`else
      return 0;
`endif
   endfunction

   // Beat j of the frame on the bus in cycle t; the frame tail comes from W+1 pad cycles.
   function automatic void push_beat(input int j, input int t);
      if (j >= W + 1) q.push_back(ref_out(j - W - 1, t + 2, 1'b0));
      if (j == N - 1) begin
         for (int d = 1; d <= W + 1; d++) begin
            q.push_back(ref_out(j + d - W - 1, t + d + 2, d == W + 1));
         end
      end
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         while (q.size() > 0 && q[0].t < cyc) begin
            check("out_late", cyc, q[0].t);
            void'(q.pop_front());
         end
         exp_v = (q.size() > 0) && (q[0].t == cyc);
         check("out_valid", out_valid, exp_v);
         if (exp_v) begin
            e = q.pop_front();
            check("out_eof", out_eof, e.eof);
            if (out_valid) begin
               check("I_dark", I_dark, e.d);
               check("min_all", min_all, e.m);
               check("rmin", rmin, e.r);
               check("gmin", gmin, e.g);
               check("bmin", bmin, e.b);
            end
            if (e.fid == fid) n_fo++;
         end else begin
            check("out_eof", out_eof, 1'b0);
         end
      end
   end

   task automatic drive_frame(input int gap_pct, input int n_pix);
      logic rdy;
      logic done;
      int   t;
      int   tries;
      fid++;
      for (int j = 0; j < n_pix; j++) begin
         done  = 1'b0;
         tries = 0;
         rdy   = 1'b0;
         while (!done && tries < 100) begin
            if (int'($urandom_range(99)) < gap_pct) begin
               in_valid = 1'b0;
               sof      = 1'b0;
               @(posedge clk); #1;
            end else begin
               in_valid = 1'b1;
               sof      = (j == 0);
               {r_in, g_in, b_in} = img[j / W][j % W];
               rdy = in_ready;
               t   = cyc;
               @(posedge clk); #1;
               if (rdy) begin
                  push_beat(j, t);
                  done = 1'b1;
               end else begin
                  tries++;
               end
            end
         end
         if (!done) begin
            check("in_ready_timeout", rdy, 1'b1);
            break;
         end
      end
      in_valid = 1'b0;
      sof      = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      in_valid = 1'b0;
      sof      = 1'b0;
      while (q.size() > 0 && i < 200) begin
         @(posedge clk); #1;
         i++;
      end
      @(posedge clk); #1;
      check("drain_done", q.size(), 0);
   endtask

   task automatic fill(input logic [23:0] v);
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++) img[yy][xx] = v;
   endtask

   task automatic fill_random();
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++) img[yy][xx] = 24'($urandom);
   endtask

   task automatic full_frame(input string tag, input int gap_pct);
      n_fo = 0;
      drive_frame(gap_pct, N);
      wait_idle();
      check({tag, "_count"}, n_fo, N);
      check({tag, "_dark_max"}, dark_max, exp_dark_max());
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_eof", out_eof, 1'b0);
      check("rst_I_dark", I_dark, 8'h00);
      check("rst_min_all", min_all, 8'h00);
      check("rst_rmin", rmin, 8'h00);
      check("rst_gmin", gmin, 8'h00);
      check("rst_bmin", bmin, 8'h00);
      check("rst_dark_max", dark_max, 8'h00);
      rst_n = 1'b1;
      #1;
      check("in_ready_after_rst", in_ready, 1'b1);
      @(posedge clk); #1;
      mon_en = 1'b1;

      // Beats without sof in IDLE are swallowed and produce nothing.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         sof      = 1'b0;
         {r_in, g_in, b_in} = 24'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;

      fill(24'hC8_9664);
      full_frame("uniform", 0);

      fill(24'hC8_9664);
      img[2][3] = 24'h0A_FAFA;
      full_frame("single_px", 0);

      fill(24'hFF_FFFF);
      img[0][0] = 24'h05_0505;
      full_frame("corner", 0);

      for (int f = 0; f < 3; f++) begin
         fill_random();
         full_frame("rand_nogap", 0);
         full_frame("rand_gap", 50);
      end

      fill_random();
      drive_frame(30, 13);
      fill(24'hC8_9664);
      full_frame("restart", 30);

      fill(24'hC8_9664);
      drive_frame(0, 20);
      in_valid = 1'b0;
      sof      = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("mid_rst_in_ready", in_ready, 1'b0);
      while (q.size() > 0 && q[$].t > cyc) void'(q.pop_back());
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1'b1);
      check("post_rst_dark_max", dark_max, 8'h00);
      @(posedge clk); #1;
      fill(24'hC8_9664);
      full_frame("after_rst", 0);

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at cycle %0d, expected completion", cyc);
      $fatal(1);
   end

endmodule

// File: doc/dark_channel_min_filter.md
# dark_channel_min_filter

Streaming 3x3 minimum-filter stage that sits directly upstream of the atmospheric-light estimation stage. It accepts raster-order RGB pixels and produces the windowed dark channel `I_dark` plus the minimum values that stage consumes: `min_all`, `rmin`, `gmin` and `bmin`. Two internal line buffers hold the previous rows. An FSM drains the frame tail so that every input pixel yields exactly one output.

## Interface
- `IMG_W`, 64: pixels per line (≥4).
- `IMG_H`, 48: lines per frame (≥3).
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts a beat this cycle.
- `sof`  in  1  first pixel of frame; sampled only on an accepted beat.
- `r_in`, `g_in`, `b_in`  in  8 each  pixel channels.
- `out_valid`  out  1  output beat; there is no backpressure.
- `I_dark`  out  8  3x3 minimum of per-pixel min(R,G,B).
- `min_all`  out  8  min(R,G,B) of the centre pixel, unfiltered.
- `rmin`, `gmin`, `bmin`  out  8 each  3x3 per-channel minima.
- `out_eof`  out  1  marks the last output beat of the frame.
- `dark_max`  out  8  maximum `I_dark` over the frame (macro-dependent).

## Operation
- Accept: an input beat is accepted when `in_valid && in_ready`. The block does not advance on cycles with no accepted beat, except in DRAIN.
- Counters: column `x` (0..IMG_W-1) and row `y` (0..IMG_H-1) increment on each consumed beat. `x` wraps to 0 and increments `y`.
- Line buffers: two buffers, each IMG_W x 24 bits, hold rows y-1 and y-2. They are written at index `x` on each consumed beat and rotate at end of line.
- Window: a 3x3 register window shifts in {row y-2, row y-1, current} each beat.
  - Positions outside the frame are forced to 8'hFF: row <0, row ≥IMG_H, column <0, column ≥IMG_W.
  - Column wrap uses a delayed copy of `x` for masking.
- Output mapping: output k is the window centred on raster pixel k. It is produced from consumed beat k+IMG_W+1. Beats with index ≥IMG_W*IMG_H are DRAIN pad beats with value 8'hFF.
- Arithmetic: all results are unsigned 8-bit minima; no widening is needed.
- FSM states:
  - IDLE: `in_ready`=1. An accepted beat with `sof`=1 loads x=1, y=0 and goes to FILL. Beats without `sof` are accepted and discarded.
  - FILL: `in_ready`=1. No output until IMG_W+1 beats are consumed, then go to RUN.
  - RUN: `in_ready`=1 and one output per consumed beat. After pixel IMG_W*IMG_H-1 is consumed, go to DRAIN.
  - DRAIN: `in_ready`=0. Inserts one pad beat per cycle, IMG_W+1 beats in total. `out_eof` is asserted with the final output, then go to IDLE.
- Restart: an accepted beat with `sof`=1 in FILL or RUN restarts the frame at that pixel. Pending outputs of the old frame are dropped and no `out_eof` is emitted for it.
- Reset: `rst_n`=0 at any point returns the FSM to IDLE and clears counters and pipeline valid bits.
  - Line-buffer RAM is not cleared; masking by `y` makes stale contents invisible.
  - `in_ready` is 0 while `rst_n`=0.

## Timing
- Latency: the output for beat k+IMG_W+1 appears with `out_valid`=1 exactly 2 cycles after that beat is consumed.
  - Stage 1: window register.
  - Stage 2: min tree and output register.
- Throughput: one pixel per cycle. Input gaps produce matching `out_valid` gaps.
- Drain: the block is busy for IMG_W+1 cycles after the last pixel. The next `sof` is accepted once the FSM is back in IDLE.
- Reset values: `out_valid`=0, `out_eof`=0, `in_ready`=0 during reset and 1 in the first cycle after reset. `I_dark`, `min_all`, `rmin`, `gmin`, `bmin` and `dark_max` all reset to 8'h00.

## Configuration
- `DCP_FRAME_STATS_EN` defined:
  - `dark_max` tracks the running maximum of `I_dark` and is reset to 0 on each new `sof`.
  - It holds the final frame value from `out_eof` until the next `sof`.
- `DCP_FRAME_STATS_EN` undefined: `dark_max` is tied to 8'h00 and no tracking logic is built.

## Test plan
- Uniform frame, all pixels (200,150,100), IMG_W=8, IMG_H=4:
  - exactly 32 outputs;
  - every output has `I_dark`=100, `min_all`=100, `rmin`=200, `gmin`=150, `bmin`=100;
  - `out_eof` on output 31 only.
- Same frame with a single pixel (10,250,250) at (3,2): `I_dark`=10 for centres x∈{2..4}, y∈{1..3}, and 100 elsewhere; `min_all`=10 only at (3,2).
- Corner pixel (0,0)=(5,5,5), rest 255:
  - `I_dark`=5 at centres (0,0), (1,0), (0,1), (1,1) only;
  - x=IMG_W-1 centres of row 1 do not see the value through column wrap.
- Random `in_valid` gaps (50%): the output sequence is identical to the gap-free run, and each output arrives exactly 2 cycles after its trigger beat.
- `sof` reasserted at pixel 13 of a frame: no `out_eof` for the aborted frame; the new frame yields a full 32 outputs.
- `rst_n` low for 1 cycle mid-RUN: `out_valid`=0 the next cycle, FSM in IDLE, and a following clean frame matches the uniform-frame result. With `DCP_FRAME_STATS_EN`, `dark_max`=100 after `out_eof`.
